// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed 7-segment driver: double-buffered hex word, programmable
// dwell, full hex decode, leading-zero blanking and pin polarity select.
module seven_seg_scan_driver #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 1000,
    parameter bit ACTIVE_LOW  = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] value_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    load,
    input  logic                    lz_en,
    output logic [6:0]              seg_out,
    output logic                    dp_out,
    output logic [NUM_DIGITS-1:0]   an_out,
    output logic                    pending
);

    localparam int IDXW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PSW  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    localparam logic [IDXW-1:0]       IDX_LAST = IDXW'(NUM_DIGITS - 1);
    localparam logic [PSW-1:0]        PS_LAST  = PSW'(REFRESH_DIV - 1);
    localparam logic [6:0]            SEG_POL  = {7{ACTIVE_LOW}};
    localparam logic [NUM_DIGITS-1:0] AN_POL   = {NUM_DIGITS{ACTIVE_LOW}};

    logic [4*NUM_DIGITS-1:0] shadow_value;
    logic [NUM_DIGITS-1:0]   shadow_dp;
    logic                    shadow_lz;
    logic [4*NUM_DIGITS-1:0] disp_value;
    logic [NUM_DIGITS-1:0]   disp_dp;
    logic                    disp_lz;
    logic [PSW-1:0]          prescaler;
    logic [IDXW-1:0]         digit_idx;

    logic                    wrap;
    logic                    frame_end;
    logic [NUM_DIGITS-1:0]   blank_vec;
    logic [NUM_DIGITS-1:0]   an_next;
    logic [3:0]              sel_nib;
    logic                    sel_dp;
    logic                    sel_blank;
    logic                    zero_run;
    logic [6:0]              seg_next;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0:    s = 7'h7E;
            4'h1:    s = 7'h30;
            4'h2:    s = 7'h6D;
            4'h3:    s = 7'h79;
            4'h4:    s = 7'h33;
            4'h5:    s = 7'h5B;
            4'h6:    s = 7'h5F;
            4'h7:    s = 7'h70;
            4'h8:    s = 7'h7F;
            4'h9:    s = 7'h7B;
            4'hA:    s = 7'h77;
            4'hB:    s = 7'h1F;
            4'hC:    s = 7'h4E;
            4'hD:    s = 7'h3D;
            4'hE:    s = 7'h4F;
            default: s = 7'h47;
        endcase
        return s;
    endfunction

    assign wrap      = (prescaler == PS_LAST);
    assign frame_end = wrap && (digit_idx == IDX_LAST);

    // A digit is blanked only if it and every more significant digit are zero.
    always_comb begin
        zero_run  = 1'b1;
        blank_vec = '0;
        an_next   = '0;
        sel_nib   = '0;
        sel_dp    = 1'b0;
        sel_blank = 1'b0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run     = zero_run && (disp_value[4*i +: 4] == 4'h0);
            blank_vec[i] = disp_lz && zero_run && (i != 0);
        end
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (digit_idx == IDXW'(i)) begin
                an_next[i] = 1'b1;
                sel_nib    = disp_value[4*i +: 4];
                sel_dp     = disp_dp[i];
                sel_blank  = blank_vec[i];
            end
        end
        seg_next = sel_blank ? 7'h00 : hex_to_seg(sel_nib);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_value <= '0;
            shadow_dp    <= '0;
            shadow_lz    <= 1'b0;
            disp_value   <= '0;
            disp_dp      <= '0;
            disp_lz      <= 1'b0;
            prescaler    <= '0;
            digit_idx    <= '0;
            pending      <= 1'b0;
            seg_out      <= SEG_POL;
            dp_out       <= ACTIVE_LOW;
            an_out       <= AN_POL;
        end else begin
            prescaler <= wrap ? '0 : prescaler + 1'b1;
            if (wrap) begin
                digit_idx <= (digit_idx == IDX_LAST) ? '0 : digit_idx + 1'b1;
            end
            if (load) begin
                shadow_value <= value_in;
                shadow_dp    <= dp_in;
                shadow_lz    <= lz_en;
            end
            // Display only changes on a frame boundary so a frame never mixes words.
            if (load && frame_end) begin
                disp_value <= value_in;
                disp_dp    <= dp_in;
                disp_lz    <= lz_en;
                pending    <= 1'b0;
            end else if (load) begin
                pending <= 1'b1;
            end else if (frame_end) begin
                if (pending) begin
                    disp_value <= shadow_value;
                    disp_dp    <= shadow_dp;
                    disp_lz    <= shadow_lz;
                end
                pending <= 1'b0;
            end
            seg_out <= seg_next ^ SEG_POL;
            dp_out  <= sel_dp ^ ACTIVE_LOW;
            an_out  <= an_next ^ AN_POL;
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Directed bench for seven_seg_scan_driver: one active-high and one
// active-low instance, N=4 digits, 4-cycle dwell.
module tb_seven_seg_scan_driver;

    logic        clk;
    logic        rst;

    logic [15:0] value_a;
    logic [3:0]  dp_a;
    logic        load_a;
    logic        lz_a;
    logic [6:0]  seg_a;
    logic        dpo_a;
    logic [3:0]  an_a;
    logic        pend_a;

    logic [15:0] value_b;
    logic [3:0]  dp_b;
    logic        load_b;
    logic        lz_b;
    logic [6:0]  seg_b;
    logic        dpo_b;
    logic [3:0]  an_b;
    logic        pend_b;

    int checks;
    int errors;
    int k;

    seven_seg_scan_driver #(
        .NUM_DIGITS (4),
        .REFRESH_DIV(4),
        .ACTIVE_LOW (1'b0)
    ) dut_a (
        .clk     (clk),
        .rst     (rst),
        .value_in(value_a),
        .dp_in   (dp_a),
        .load    (load_a),
        .lz_en   (lz_a),
        .seg_out (seg_a),
        .dp_out  (dpo_a),
        .an_out  (an_a),
        .pending (pend_a)
    );

    seven_seg_scan_driver #(
        .NUM_DIGITS (4),
        .REFRESH_DIV(4),
        .ACTIVE_LOW (1'b1)
    ) dut_b (
        .clk     (clk),
        .rst     (rst),
        .value_in(value_b),
        .dp_in   (dp_b),
        .load    (load_b),
        .lz_en   (lz_b),
        .seg_out (seg_b),
        .dp_out  (dpo_b),
        .an_out  (an_b),
        .pending (pend_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        k++;
    endtask

    task automatic advance_to(input int t);
        while (k < t) tick();
    endtask

    task automatic check_a(input string tag, input int d,
                           input logic [6:0] seg, input logic dp);
        logic [3:0] an_exp;
        an_exp = 4'(1 << d);
        check({tag, ".an"}, 32'(an_a), 32'(an_exp));
        check({tag, ".seg"}, 32'(seg_a), 32'(seg));
        check({tag, ".dp"}, 32'(dpo_a), 32'(dp));
    endtask

    task automatic load_a_word(input logic [15:0] v, input logic [3:0] d,
                               input logic lz);
        value_a = v;
        dp_a    = d;
        lz_a    = lz;
        load_a  = 1'b1;
        tick();
        load_a  = 1'b0;
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        k       = 0;
        rst     = 1'b1;
        value_a = '0; dp_a = '0; load_a = 1'b0; lz_a = 1'b0;
        value_b = '0; dp_b = '0; load_b = 1'b0; lz_b = 1'b0;

        #22;
        check("rst_a.an", 32'(an_a), 32'h0);
        check("rst_a.seg", 32'(seg_a), 32'h0);
        check("rst_a.dp", 32'(dpo_a), 32'h0);
        check("rst_a.pend", 32'(pend_a), 32'h0);
        check("rst_b.an", 32'(an_b), 32'hF);
        check("rst_b.seg", 32'(seg_b), 32'h7F);
        check("rst_b.dp", 32'(dpo_b), 32'h1);

        @(negedge clk);
        rst = 1'b0;
        k   = 0;

        // Scan walk with cleared display
        advance_to(1);  check_a("walk0", 0, 7'h7E, 1'b0);
        advance_to(5);  check_a("walk1", 1, 7'h7E, 1'b0);
        advance_to(9);  check_a("walk2", 2, 7'h7E, 1'b0);
        advance_to(13); check_a("walk3", 3, 7'h7E, 1'b0);

        // Mid-frame load, shown from the next frame
        load_a_word(16'hA3F0, 4'b0100, 1'b0);
        check("a3f0.pend14", 32'(pend_a), 32'h1);
        check("a3f0.seg14", 32'(seg_a), 32'h7E);
        advance_to(15); check("a3f0.pend15", 32'(pend_a), 32'h1);
        advance_to(16); check("a3f0.pend16", 32'(pend_a), 32'h0);
        advance_to(17); check_a("a3f0.d0", 0, 7'h7E, 1'b0);

        // Two loads in one frame: last one wins
        advance_to(18);
        load_a_word(16'h1234, 4'b0000, 1'b0);
        advance_to(21); check_a("a3f0.d1", 1, 7'h47, 1'b0);
        advance_to(22);
        load_a_word(16'h5678, 4'b0000, 1'b0);
        advance_to(25); check_a("a3f0.d2", 2, 7'h79, 1'b1);
        advance_to(29); check_a("a3f0.d3", 3, 7'h77, 1'b0);
        check("5678.pend29", 32'(pend_a), 32'h1);
        advance_to(33); check_a("5678.d0", 0, 7'h7F, 1'b0);
        check("5678.pend33", 32'(pend_a), 32'h0);

        // Leading-zero blanking
        advance_to(34);
        load_a_word(16'h0050, 4'b0000, 1'b1);
        advance_to(37); check_a("5678.d1", 1, 7'h70, 1'b0);
        advance_to(41); check_a("5678.d2", 2, 7'h5F, 1'b0);
        advance_to(45); check_a("5678.d3", 3, 7'h5B, 1'b0);
        advance_to(49); check_a("lz50.d0", 0, 7'h7E, 1'b0);
        advance_to(50);
        load_a_word(16'h0000, 4'b1000, 1'b1);
        advance_to(53); check_a("lz50.d1", 1, 7'h5B, 1'b0);
        advance_to(57); check_a("lz50.d2", 2, 7'h00, 1'b0);
        advance_to(61); check_a("lz50.d3", 3, 7'h00, 1'b0);
        advance_to(65); check_a("lz00.d0", 0, 7'h7E, 1'b0);
        advance_to(69); check_a("lz00.d1", 1, 7'h00, 1'b0);
        advance_to(73); check_a("lz00.d2", 2, 7'h00, 1'b0);
        advance_to(77); check_a("lz00.d3", 3, 7'h00, 1'b1);

        // Active-low instance: load captured on frame-boundary edge 80
        advance_to(79);
        value_b = 16'h0008;
        dp_b    = 4'b0000;
        lz_b    = 1'b0;
        load_b  = 1'b1;
        tick();
        load_b  = 1'b0;
        check("b.pend80", 32'(pend_b), 32'h0);
        advance_to(81);
        check("b.pend81", 32'(pend_b), 32'h0);
        check("b.d0.an", 32'(an_b), 32'hE);
        check("b.d0.seg", 32'(seg_b), 32'h00);
        check("b.d0.dp", 32'(dpo_b), 32'h1);

        // Asynchronous reset with pending data
        advance_to(82);
        load_a_word(16'hFFFF, 4'b1111, 1'b0);
        check("rst2.pend83", 32'(pend_a), 32'h1);
        advance_to(85);
        check("b.d1.an", 32'(an_b), 32'hD);
        check("b.d1.seg", 32'(seg_b), 32'h01);
        #2;
        rst = 1'b1;
        #1;
        check("rst2.an", 32'(an_a), 32'h0);
        check("rst2.seg", 32'(seg_a), 32'h0);
        check("rst2.dp", 32'(dpo_a), 32'h0);
        check("rst2.pend", 32'(pend_a), 32'h0);
        check("rst2_b.an", 32'(an_b), 32'hF);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        k   = 0;
        advance_to(1);  check_a("post.d0", 0, 7'h7E, 1'b0);
        advance_to(17); check_a("post.f1d0", 0, 7'h7E, 1'b0);
        check("post.pend", 32'(pend_a), 32'h0);
        advance_to(21); check_a("post.f1d1", 1, 7'h7E, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seven_seg_scan_driver.md
# seven_seg_scan_driver

Parametrised, time-multiplexed driver for an array of common-anode/cathode 7-segment digits. Accepts a packed hex word plus decimal points through a load strobe, double-buffers it, and scans one digit at a time with a programmable dwell, applying full hex decoding, optional leading-zero blanking and selectable output polarity. Sits between the datapath and the board display pins, replacing per-digit combinational decoders.

## Interface
- NUM_DIGITS, 4, number of digits scanned (1..16).
- REFRESH_DIV, 1000, clock cycles each digit stays selected (>=1).
- ACTIVE_LOW, 0, 1 inverts seg_out, dp_out and an_out at the pins.

- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- value_in  input  4*NUM_DIGITS  hex nibbles; nibble i (bits 4i+3:4i) is digit i, digit 0 least significant.
- dp_in  input  NUM_DIGITS  decimal point per digit, 1 = lit.
- load  input  1  one-cycle strobe capturing value_in/dp_in/lz_en into the shadow buffer.
- lz_en  input  1  leading-zero suppression enable, captured with load.
- seg_out  output  7  segments {a,b,c,d,e,f,g}, bit 6 = a.
- dp_out  output  1  decimal point of the selected digit.
- an_out  output  NUM_DIGITS  one-hot digit select, bit i = digit i.
- pending  output  1  shadow holds data not yet displayed.

## Operation
- Registers: shadow (value, dp, lz), display (value, dp, lz), prescaler, digit_idx, pending, output registers.
- Prescaler counts 0..REFRESH_DIV-1; at terminal count it wraps to 0 and digit_idx increments, N-1 wraps to 0.
- Frame boundary = prescaler terminal count with digit_idx == NUM_DIGITS-1. At that edge, if pending: display <= shadow, pending <= 0.
- load: shadow <= inputs, pending <= 1. Load while pending overwrites shadow (last wins). Load on a frame-boundary cycle: inputs go straight to display, pending stays 0.
- Decode (logical, before polarity), hex 0..F: 7E,30,6D,79,33,5B,5F,70,7F,7B,77,1F,4E,3D,4F,47.
- Leading-zero blanking: digit i (i>0) blanked when display lz set and nibbles i..N-1 all zero; blanked digit drives seg=00, but its dp still follows dp_in. Digit 0 never blanked.
- Output registers each cycle: an_out = onehot(digit_idx), seg_out = decode(display nibble[digit_idx]) or blank, dp_out = display dp[digit_idx]; then XOR with ACTIVE_LOW.
- No states besides the scan counter; no gaps between digits (anode switch and segment change occur on the same edge).

## Timing
- Reset (async assert, any time, including mid-frame or with pending): prescaler 0, digit_idx 0, shadow/display 0, pending 0; an_out, seg_out, dp_out all inactive (0s, or all 1s when ACTIVE_LOW).
- First edge after reset release: an_out selects digit 0, seg_out = decode(0) = 7E (display cleared, lz 0).
- Output latency: one cycle from digit_idx/display change to pins.
- Digit dwell REFRESH_DIV cycles; frame NUM_DIGITS*REFRESH_DIV cycles.
- pending rises the edge after load; display update latency 1..frame cycles, at a frame boundary only, so a frame never mixes old and new values.
- REFRESH_DIV = 1: digit changes every cycle, every digit-(N-1) cycle is a frame boundary.
- NUM_DIGITS = 1: an_out constant 1 (logical), every prescaler wrap is a frame boundary.

## Test plan
- Reset, N=4, DIV=4, ACTIVE_LOW=0: outputs 0 during reset; after release an_out walks 0001,0010,0100,1000 every 4 cycles with seg_out 7E each.
- load value 16'hA3F0, dp 4'b0100 mid-frame: pending=1 until next boundary, then digits 0..3 show 7E,47,79 (dp=1),77; pending=0.
- Two loads (1234 then 5678) within one frame: only 5678 ever appears (seg 7F,70,5F,5B), never 1234.
- lz_en=1, value 16'h0050: digits 3,2 seg=00, digit 1 seg=5B, digit 0 seg=7E; value 0000 shows only digit 0 = 7E.
- ACTIVE_LOW=1, load on exact frame-boundary cycle with 16'h0008: display updates on that edge, pending never rises, digit 0 seg_out = 7'h00, an_out = 1110.
- Assert rst mid-frame with pending=1: outputs inactive immediately (asynchronously), after release shadow discarded and display shows 0000.
